// File: rtl/seq_booth_mult.sv
// Iterative radix-2 Booth multiplier, signed/unsigned selectable, fixed WA+1 step latency.
// Define SEQ_BOOTH_MULT_ACC_EN to add the acc input (multiply-accumulate onto the held p).
`timescale 1ns/1ps

module seq_booth_mult #(
  parameter  int WA = 8,
  parameter  int WB = 8,
  localparam int W  = WA + WB
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          tc,
`ifdef SEQ_BOOTH_MULT_ACC_EN
  input  logic          acc,
`endif
  input  logic [WA-1:0] a,
  input  logic [WB-1:0] b,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  p
);

  localparam int            CW   = $clog2(WA + 1);
  localparam logic [CW-1:0] LAST = CW'(WA);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [WA:0]   mr;
  logic          q_m1;
  logic [W:0]    md;
  logic [W:0]    pp;
  logic [CW-1:0] cnt;

  logic [W:0]    md_sh;
  logic [W:0]    pp_next;
  logic [W:0]    pp_init;

  // One Booth step: the pair {current multiplier bit, previous bit} selects +b, -b or nothing.
  always_comb begin
    md_sh   = md << cnt;
    pp_next = pp;
    unique case ({mr[0], q_m1})
      2'b01:   pp_next = pp + md_sh;
      2'b10:   pp_next = pp - md_sh;
      default: pp_next = pp;
    endcase
  end

`ifdef SEQ_BOOTH_MULT_ACC_EN
  assign pp_init = acc ? {tc & p[W-1], p} : '0;
`else
  assign pp_init = '0;
`endif

  // NOTE: all state here is registered with <= so every register sees pre-edge values,
  // and every register, including the operand and partial-product registers, is reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      p     <= '0;
      mr    <= '0;
      q_m1  <= 1'b0;
      md    <= '0;
      pp    <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mr    <= {tc & a[WA-1], a};
            md    <= {{(W + 1 - WB){tc & b[WB-1]}}, b};
            pp    <= pp_init;
            q_m1  <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          pp   <= pp_next;
          mr   <= {mr[WA], mr[WA:1]};
          q_m1 <= mr[0];
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            p     <= pp_next[W-1:0];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_booth_mult.sv
// Randomized self-checking bench for seq_booth_mult (WA=WB=8) against an arithmetic model.
`timescale 1ns/1ps

module tb_seq_booth_mult;

  localparam int WA  = 8;
  localparam int WB  = 8;
  localparam int W   = WA + WB;
  localparam int LAT = WA + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          tc;
`ifdef SEQ_BOOTH_MULT_ACC_EN
  logic          acc;
`endif
  logic [WA-1:0] a;
  logic [WB-1:0] b;
  logic          busy;
  logic          done;
  logic [W-1:0]  p;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] model_p = '0;

  always #5 clk = ~clk;

  seq_booth_mult #(.WA(WA), .WB(WB)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .tc    (tc),
`ifdef SEQ_BOOTH_MULT_ACC_EN
    .acc   (acc),
`endif
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Plain-arithmetic reference: operand values by mode, product (plus previous p) mod 2^W.
  function automatic logic [W-1:0] model(input logic t, input logic [WA-1:0] x,
                                         input logic [WB-1:0] y, input logic ac,
                                         input logic [W-1:0] prev);
    longint vx, vy, s;
    vx = t ? longint'($signed(x)) : longint'(x);
    vy = t ? longint'($signed(y)) : longint'(y);
    s  = vx * vy + (ac ? longint'(prev) : 64'sd0);
    return s[W-1:0];
  endfunction

  task automatic set_inputs(input logic st, input logic t, input logic [WA-1:0] x,
                            input logic [WB-1:0] y, input logic ac);
    start = st;
    tc    = t;
    a     = x;
    b     = y;
`ifdef SEQ_BOOTH_MULT_ACC_EN
    acc   = ac;
`else
    if (ac) $display("acc requested without accumulate build");
`endif
  endtask

  // Full operation: start pulse, then operands scrambled while running, latency/pulse/hold checks.
  task automatic run_op(input string tag, input logic t, input logic [WA-1:0] x,
                        input logic [WB-1:0] y, input logic ac);
    logic [W-1:0] exp_p;
    int lat;
    exp_p = model(t, x, y, ac, model_p);
    @(negedge clk);
    set_inputs(1'b1, t, x, y, ac);
    @(posedge clk); #1;
    check({tag, "_busy_start"}, busy, 1'b1);
    @(negedge clk);
    set_inputs(1'b0, 1'($urandom), WA'($urandom), WB'($urandom), 1'($urandom));
    lat = 0;
    for (int i = 1; i <= 3 * LAT; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
      if (!busy) begin
        lat = -i;
        break;
      end
    end
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_p"}, p, exp_p);
    check({tag, "_busy_end"}, busy, 1'b0);
    model_p = exp_p;
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_p_hold"}, p, exp_p);
  endtask

  initial begin
    bit saw_done;
    rst = 1'b0;
    set_inputs(1'b0, 1'b0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_p", p, '0);
    @(negedge clk) rst = 1'b1;

    run_op("s_m128sq", 1'b1, 8'h80, 8'h80, 1'b0);
    check("s_m128sq_val", model_p, 16'h4000);
    run_op("s_m3x5", 1'b1, 8'hFD, 8'h05, 1'b0);
    check("s_m3x5_val", model_p, 16'hFFF1);
    run_op("s_127xm128", 1'b1, 8'h7F, 8'h80, 1'b0);
    check("s_127xm128_val", model_p, 16'hC080);
    run_op("u_ffxff", 1'b0, 8'hFF, 8'hFF, 1'b0);
    check("u_ffxff_val", model_p, 16'hFE01);
    run_op("u_zero", 1'b0, 8'h00, 8'hAB, 1'b0);

    // Starts during RUN (cycle 3) and on the done edge (cycle 9) must be ignored.
    @(negedge clk);
    set_inputs(1'b1, 1'b0, 8'd6, 8'd7, 1'b0);
    @(posedge clk);
    for (int cyc = 1; cyc <= LAT; cyc++) begin
      @(negedge clk);
      set_inputs(cyc == 3 || cyc == LAT, 1'b0, 8'd2, 8'd2, 1'b0);
      @(posedge clk); #1;
      if (cyc == 3) check("ign_busy_c3", busy, 1'b1);
    end
    check("ign_done", done, 1'b1);
    check("ign_p", p, 16'd42);
    model_p = 16'd42;
    @(negedge clk);
    set_inputs(1'b0, 1'b0, 8'd2, 8'd2, 1'b0);
    @(posedge clk); #1;
    check("ign_not_accepted", busy, 1'b0);
    run_op("after_ign", 1'b0, 8'd2, 8'd2, 1'b0);

    // Asynchronous reset mid-operation abandons the multiply.
    @(negedge clk);
    set_inputs(1'b1, 1'b0, 8'd9, 8'd9, 1'b0);
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_p", p, '0);
    model_p = '0;
    @(negedge clk) rst = 1'b1;
    saw_done = 1'b0;
    repeat (2 * LAT) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("arst_no_done", saw_done, 1'b0);
    run_op("arst_next", 1'b0, 8'd3, 8'd3, 1'b0);
    check("arst_next_val", model_p, 16'd9);

`ifdef SEQ_BOOTH_MULT_ACC_EN
    run_op("acc0", 1'b0, 8'd3, 8'd4, 1'b0);
    check("acc0_val", model_p, 16'd12);
    run_op("acc1", 1'b0, 8'd2, 8'd5, 1'b1);
    check("acc1_val", model_p, 16'd22);
    run_op("acc_neg", 1'b1, 8'hFF, 8'd22, 1'b1);
    check("acc_neg_val", model_p, 16'd0);
`endif

    for (int n = 0; n < 30; n++) begin
`ifdef SEQ_BOOTH_MULT_ACC_EN
      run_op("rand", 1'($urandom), WA'($urandom), WB'($urandom), 1'($urandom));
`else
      run_op("rand", 1'($urandom), WA'($urandom), WB'($urandom), 1'b0);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
